seven_seg_scanner: RTL and testbench

Time-multiplexed driver for a common-anode multi-digit seven-segment display. It consumes the divided clock from the clock divider as a level signal and edge-detects it in the system clock domain. Each rising edge advances the lit digit by one position. The displayed value is snapshotted once per scan frame so the panel never shows a mix of old and new digits.

---
 rtl/seven_seg_pkg.sv | 10 +
 rtl/hex_to_7seg.sv | 9 +
 rtl/seven_seg_scanner.sv | 91 +++++++++
 tb/tb_seven_seg_scanner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment type, active-low {g,f,e,d,c,b,a} hex font and scan states for seven_seg_scanner
package seven_seg_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_OFF = 7'h7F;
    localparam seg_t HEX_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic {IDLE, SCAN} scan_state_e;
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low segment lookup
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);
    assign o_seg = HEX_FONT[i_nibble];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: tick-driven multiplexed display scanner; define SEVEN_SEG_SCANNER_LZB_EN for leading-zero blanking
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int IDX_W    = $clog2(N_DIGITS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_enable,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blank,
    output logic [N_DIGITS-1:0]   o_anodes,
    output seg_t                  o_segments,
    output logic                  o_dp,
    output logic [IDX_W-1:0]      o_digit_idx
);
    scan_state_e           state, state_n;
    logic                  tick_q, armed, tick_rise, latch, lit;
    logic [IDX_W-1:0]      idx_n;
    logic [4*N_DIGITS-1:0] val_sh, val_n;
    logic [N_DIGITS-1:0]   dp_sh, dp_n, blank_sh, blank_n, lzb;
    seg_t                  seg;
    assign tick_rise = i_tick & ~tick_q & armed;
`ifdef SEVEN_SEG_SCANNER_LZB_EN
    logic run;
    always_comb begin
        run = 1'b1;
        lzb = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            run    = run & (i_value[4*i +: 4] == 4'h0);
            lzb[i] = run;
        end
    end
`else
    assign lzb = '0;
`endif
    always_comb begin
        state_n = state;
        idx_n   = o_digit_idx;
        latch   = 1'b0;
        if (state == IDLE) begin
            if (tick_rise && i_enable) begin
                state_n = SCAN;
                idx_n   = '0;
                latch   = 1'b1;
            end
        end else if (!i_enable) begin
            state_n = IDLE;
            idx_n   = '0;
        end else if (tick_rise) begin
            latch = (o_digit_idx == IDX_W'(N_DIGITS - 1));
            idx_n = latch ? '0 : o_digit_idx + 1'b1;
        end
        val_n   = latch ? i_value : val_sh;
        dp_n    = latch ? i_dp : dp_sh;
        blank_n = latch ? (i_blank | lzb) : blank_sh;
        lit     = (state_n == SCAN) && !blank_n[idx_n];
    end
    hex_to_7seg u_font (
        .i_nibble (val_n[4*idx_n +: 4]),
        .o_seg    (seg)
    );
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= IDLE;
            tick_q      <= 1'b0;
            armed       <= 1'b0;
            val_sh      <= '0;
            dp_sh       <= '0;
            blank_sh    <= '0;
            o_anodes    <= '1;
            o_segments  <= SEG_OFF;
            o_dp        <= 1'b1;
            o_digit_idx <= '0;
        end else begin
            state       <= state_n;
            tick_q      <= i_tick;
            armed       <= 1'b1;
            val_sh      <= val_n;
            dp_sh       <= dp_n;
            blank_sh    <= blank_n;
            o_anodes    <= (state_n == SCAN) ? ~(N_DIGITS'(1) << idx_n) : '1;
            o_segments  <= lit ? seg : SEG_OFF;
            o_dp        <= ~(lit && dp_n[idx_n]);
            o_digit_idx <= idx_n;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: table-driven scoreboard bench for seven_seg_scanner
module tb_seven_seg_scanner;
    typedef struct {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        en;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dpo;
        logic [2:0]  idx;
    } vec_t;
    typedef struct {
        string      name;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dpo;
        logic [2:0] idx;
    } exp_t;
    localparam logic [31:0] V = 32'h0123_4567;
    localparam logic [31:0] F = 32'hFFFF_FFFF;
    logic        clk = 1'b0;
    logic        rst_n, tick, en;
    logic [31:0] value;
    logic [7:0]  dp, blank, anodes;
    logic [6:0]  segments;
    logic        dpo;
    logic [2:0]  idx;
    vec_t        tbl[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    seven_seg_scanner dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_tick      (tick),
        .i_enable    (en),
        .i_value     (value),
        .i_dp        (dp),
        .i_blank     (blank),
        .o_anodes    (anodes),
        .o_segments  (segments),
        .o_dp        (dpo),
        .o_digit_idx (idx)
    );
    function automatic void add(logic [31:0] v, logic [7:0] d, logic [7:0] b, logic e,
                                logic [7:0] an, logic [6:0] sg, logic o, logic [2:0] ix);
        vec_t r;
        r.value = v; r.dp = d; r.blank = b; r.en = e;
        r.an = an; r.seg = sg; r.dpo = o; r.idx = ix;
        tbl.push_back(r);
    endfunction
    task automatic push(input string n, input logic [7:0] an, input logic [6:0] sg,
                        input logic o, input logic [2:0] ix);
        exp_t e;
        e.name = n; e.an = an; e.seg = sg; e.dpo = o; e.idx = ix;
        sb.push_back(e);
    endtask
    task automatic check_pop();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        if ({anodes, segments, dpo, idx} !== {e.an, e.seg, e.dpo, e.idx}) begin
            errors++;
            $display("FAIL %s: got an=%h seg=%h dp=%b idx=%0d, want an=%h seg=%h dp=%b idx=%0d",
                     e.name, anodes, segments, dpo, idx, e.an, e.seg, e.dpo, e.idx);
        end
    endtask
    task automatic apply(input string n, input vec_t v);
        @(negedge clk);
        value = v.value; dp = v.dp; blank = v.blank; en = v.en; tick = 1'b1;
        push(n, v.an, v.seg, v.dpo, v.idx);
        @(posedge clk);
        #1 check_pop();
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask
    task automatic tick_chk(input string n, input logic [7:0] an, input logic [6:0] sg,
                            input logic o, input logic [2:0] ix);
        vec_t v;
        v.value = value; v.dp = dp; v.blank = blank; v.en = en;
        v.an = an; v.seg = sg; v.dpo = o; v.idx = ix;
        apply(n, v);
    endtask
    task automatic reset_to(input logic [31:0] v);
        @(negedge clk);
        rst_n = 1'b0; tick = 1'b0; value = v; dp = '0; blank = '0; en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        rst_n = 1'b0; tick = 1'b0; en = 1'b1; value = V; dp = '0; blank = '0;
        add(V, 8'h00, 8'h00, 1, 8'hFE, 7'h78, 1, 0);
        add(V, 8'h00, 8'h00, 1, 8'hFD, 7'h02, 1, 1);
        add(V, 8'h00, 8'h00, 1, 8'hFB, 7'h12, 1, 2);
        add(V, 8'h00, 8'h00, 1, 8'hF7, 7'h19, 1, 3);
        add(F, 8'h00, 8'h00, 1, 8'hEF, 7'h30, 1, 4);
        add(F, 8'h00, 8'h00, 1, 8'hDF, 7'h24, 1, 5);
        add(F, 8'h00, 8'h00, 1, 8'hBF, 7'h79, 1, 6);
`ifdef SEVEN_SEG_SCANNER_LZB_EN
        add(F, 8'h00, 8'h00, 1, 8'h7F, 7'h7F, 1, 7);
`else
        add(F, 8'h00, 8'h00, 1, 8'h7F, 7'h40, 1, 7);
`endif
        add(F, 8'h00, 8'h00, 1, 8'hFE, 7'h0E, 1, 0);
        add(F, 8'h02, 8'h02, 1, 8'hFD, 7'h0E, 1, 1);
        add(F, 8'h02, 8'h02, 1, 8'hFB, 7'h0E, 1, 2);
        add(F, 8'h02, 8'h02, 1, 8'hF7, 7'h0E, 1, 3);
        add(F, 8'h02, 8'h02, 1, 8'hEF, 7'h0E, 1, 4);
        add(F, 8'h02, 8'h02, 1, 8'hDF, 7'h0E, 1, 5);
        add(F, 8'h02, 8'h02, 1, 8'hBF, 7'h0E, 1, 6);
        add(F, 8'h02, 8'h02, 1, 8'h7F, 7'h0E, 1, 7);
        add(F, 8'h02, 8'h02, 1, 8'hFE, 7'h0E, 1, 0);
        add(F, 8'h02, 8'h00, 1, 8'hFD, 7'h7F, 1, 1);
        add(F, 8'h02, 8'h00, 1, 8'hFB, 7'h0E, 1, 2);
        add(F, 8'h02, 8'h00, 1, 8'hF7, 7'h0E, 1, 3);
        add(F, 8'h02, 8'h00, 1, 8'hEF, 7'h0E, 1, 4);
        add(F, 8'h02, 8'h00, 1, 8'hDF, 7'h0E, 1, 5);
        add(F, 8'h02, 8'h00, 1, 8'hBF, 7'h0E, 1, 6);
        add(F, 8'h02, 8'h00, 1, 8'h7F, 7'h0E, 1, 7);
        add(F, 8'h02, 8'h00, 1, 8'hFE, 7'h0E, 1, 0);
        add(F, 8'h02, 8'h00, 1, 8'hFD, 7'h0E, 0, 1);
        add(F, 8'h02, 8'h00, 1, 8'hFB, 7'h0E, 1, 2);
        add(F, 8'h02, 8'h00, 1, 8'hF7, 7'h0E, 1, 3);
        add(F, 8'h02, 8'h00, 1, 8'hEF, 7'h0E, 1, 4);
        add(F, 8'h02, 8'h00, 1, 8'hDF, 7'h0E, 1, 5);
        add(F, 8'h02, 8'h00, 0, 8'hFF, 7'h7F, 1, 0);
        add(V, 8'h02, 8'h00, 1, 8'hFE, 7'h78, 1, 0);
        add(V, 8'h02, 8'h00, 1, 8'hFD, 7'h02, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick = ~tick;
            push($sformatf("reset_dark%0d", k), 8'hFF, 7'h7F, 1, 0);
            @(posedge clk);
            #1 check_pop();
        end
        @(negedge clk);
        tick = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push("idle_dark", 8'hFF, 7'h7F, 1, 0);
        check_pop();
        for (int i = 0; i < tbl.size(); i++) apply($sformatf("row%0d", i), tbl[i]);
        @(negedge clk);
        tick = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push($sformatf("tick_hold%0d", k), 8'hFB, 7'h12, 1, 2);
            @(posedge clk);
            #1 check_pop();
            @(negedge clk);
        end
        rst_n = 1'b0;
        push("reset_mid_scan", 8'hFF, 7'h7F, 1, 0);
        @(posedge clk);
        #1 check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 push($sformatf("release_tick_high%0d", k), 8'hFF, 7'h7F, 1, 0);
            check_pop();
        end
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        tick_chk("first_after_release", 8'hFE, 7'h78, 1, 0);
        reset_to(32'h0000_0400);
        en = 1'b0;
        tick_chk("idle_disabled_tick", 8'hFF, 7'h7F, 1, 0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
`ifdef SEVEN_SEG_SCANNER_LZB_EN
            tick_chk($sformatf("lz400_d%0d", i), 8'(~(8'h01 << i)),
                     (i == 2) ? 7'h19 : (i < 2) ? 7'h40 : 7'h7F, 1, 3'(i));
`else
            tick_chk($sformatf("nolz400_d%0d", i), 8'(~(8'h01 << i)),
                     (i == 2) ? 7'h19 : 7'h40, 1, 3'(i));
`endif
        end
        value = 32'h0;
        for (int i = 0; i < 8; i++) begin
`ifdef SEVEN_SEG_SCANNER_LZB_EN
            tick_chk($sformatf("lz0_d%0d", i), 8'(~(8'h01 << i)), (i == 0) ? 7'h40 : 7'h7F, 1, 3'(i));
`else
            tick_chk($sformatf("nolz0_d%0d", i), 8'(~(8'h01 << i)), 7'h40, 1, 3'(i));
`endif
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
